// File: rtl/tank_sprite_fetch.sv
// Tank sprite fetch stage: scan position -> sprite RAM address, then palette
// index -> RGB and an opaque-pixel flag. Three-edge pipeline, one pixel per cycle.
// Tank position and direction are latched once per frame so the sprite never tears.
module tank_sprite_fetch #(
    parameter int unsigned SPRITE_W = 50,
    parameter int unsigned SPRITE_H = 50,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic [9:0]        tank_x,
    input  logic [9:0]        tank_y,
    input  logic [1:0]        tank_dir,
    input  logic              pixel_valid_in,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] sprite_addr,
    output logic [1:0]        sprite_sel,
    input  logic [3:0]        sprite_data,
    output logic              pixel_valid_out,
    output logic              tank_hit,
    output logic [23:0]       tank_rgb
);

    // Frame-latched tank state
    logic [9:0] lx_q;
    logic [9:0] ly_q;
    logic [1:0] ldir_q;

    // Pipeline flags: v = active pixel, b = active pixel inside the sprite box
    logic v_a_q, b_a_q;
    logic v_b_q, b_b_q;

    // Stage A combinational signals
    logic [10:0]       x_ext, y_ext, lx_ext, ly_ext;
    logic              in_box;
    logic [9:0]        rx, ry;
    logic [ADDR_W-1:0] rx_ext, ry_ext, row_base, addr_next;

    // Stage C combinational signals
    logic        hit_next;
    logic [23:0] rgb_next;

    // Palette lookup; index 0 is transparent and maps to black
    function automatic logic [23:0] palette(input logic [3:0] idx);
        logic [23:0] rgb;
        unique case (idx)
            4'd1:    rgb = 24'h000000;
            4'd2:    rgb = 24'h2E7D32;
            4'd3:    rgb = 24'h1B5E20;
            4'd4:    rgb = 24'h66BB6A;
            4'd5:    rgb = 24'h9E9E9E;
            4'd6:    rgb = 24'h616161;
            4'd7:    rgb = 24'hFFEB3B;
            4'd8:    rgb = 24'hFF9800;
            4'd9:    rgb = 24'hF44336;
            4'd10:   rgb = 24'h795548;
            4'd11:   rgb = 24'h3E2723;
            4'd12:   rgb = 24'hFFFFFF;
            4'd13:   rgb = 24'h90CAF9;
            4'd14:   rgb = 24'h1565C0;
            4'd15:   rgb = 24'h000080;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    // Latch tank position/direction at vblank; a same-cycle pixel still sees old values
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lx_q   <= '0;
            ly_q   <= '0;
            ldir_q <= '0;
        end else if (frame_start) begin
            lx_q   <= tank_x;
            ly_q   <= tank_y;
            ldir_q <= tank_dir;
        end
    end

    // Box test in 11 bits so a sprite hanging past column 1023 cannot wrap to the left edge
    assign x_ext  = {1'b0, DrawX};
    assign y_ext  = {1'b0, DrawY};
    assign lx_ext = {1'b0, lx_q};
    assign ly_ext = {1'b0, ly_q};
    assign in_box = (x_ext >= lx_ext) && (x_ext < lx_ext + 11'(SPRITE_W)) &&
                    (y_ext >= ly_ext) && (y_ext < ly_ext + 11'(SPRITE_H));

    // Relative offsets; only meaningful inside the box, where they fit the address width
    assign rx     = DrawX - lx_q;
    assign ry     = DrawY - ly_q;
    assign rx_ext = ADDR_W'(rx);
    assign ry_ext = ADDR_W'(ry);

    // Row base ry*SPRITE_W; the 50-wide case is a shift-add so no multiplier is inferred
    if (SPRITE_W == 50) begin : g_row_shift
        assign row_base = (ry_ext << 5) + (ry_ext << 4) + (ry_ext << 1);
    end else begin : g_row_mul
        assign row_base = ry_ext * ADDR_W'(SPRITE_W);
    end

    assign addr_next = in_box ? (row_base + rx_ext) : '0;

    // Stage A: register RAM address, direction select and pixel flags
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sprite_addr <= '0;
            sprite_sel  <= '0;
            v_a_q       <= 1'b0;
            b_a_q       <= 1'b0;
        end else begin
            sprite_addr <= addr_next;
            sprite_sel  <= ldir_q;
            v_a_q       <= pixel_valid_in;
            b_a_q       <= in_box & pixel_valid_in;
        end
    end

    // Stage B: delay flags alongside the RAM's registered read
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v_b_q <= 1'b0;
            b_b_q <= 1'b0;
        end else begin
            v_b_q <= v_a_q;
            b_b_q <= b_a_q;
        end
    end

    // Stage C next-state: opaque pixel test and colour
    always_comb begin
        hit_next = 1'b0;
        rgb_next = 24'h000000;
        if (b_b_q && (sprite_data != 4'd0)) begin
            hit_next = 1'b1;
            rgb_next = palette(sprite_data);
        end
    end

    // Stage C: register outputs for the colour mapper
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_valid_out <= 1'b0;
            tank_hit        <= 1'b0;
            tank_rgb        <= '0;
        end else begin
            pixel_valid_out <= v_b_q;
            tank_hit        <= hit_next;
            tank_rgb        <= rgb_next;
        end
    end

endmodule
